// File: rtl/alien_fire_controller.sv
// ============================================================================
// Module   : alien_fire_controller
// Brief    : Picks the firing alien column, launches the alien projectile and
//            resolves projectile/player hits and the player's life count.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alien_fire_controller #(
    parameter int          NUM_COLS     = 8,
    parameter logic [9:0]  COL_SPACING  = 10'd40,
    parameter logic [9:0]  ROW_SPACING  = 10'd32,
    parameter logic [9:0]  ALIEN_W      = 10'd24,
    parameter logic [9:0]  ALIEN_H      = 10'd16,
    parameter logic [9:0]  PLAYER_W     = 10'd32,
    parameter logic [9:0]  PLAYER_H     = 10'd16,
    parameter logic [9:0]  PROJ_SIZE    = 10'd3,
    parameter logic [7:0]  COOLDOWN_MIN = 8'd30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [1:0]  INIT_LIVES   = 2'd3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic [9:0]            alien_base_x,
    input  logic [9:0]            alien_base_y,
    input  logic [NUM_COLS-1:0]   col_alive,
    input  logic [3*NUM_COLS-1:0] col_depth,
    input  logic [9:0]            player_x,
    input  logic [9:0]            player_y,
    input  logic [9:0]            projectile_x_pos,
    input  logic [9:0]            projectile_y_pos,
    output logic                  shoot,
    output logic [9:0]            shooter_x,
    output logic [9:0]            shooter_y,
    output logic                  is_hit,
    output logic                  player_hit,
    output logic [1:0]            lives,
    output logic                  game_over
);

    localparam logic [2:0] S_COOLDOWN = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_FLIGHT   = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [15:0] c_LFSR_MASK = 16'hB400;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_frame_d;
    logic        r_frame_edge;
    logic [15:0] r_lfsr;
    logic [7:0]  r_cd_cnt;
    logic [2:0]  r_col_sel;
    logic        r_hit_done;
    logic        r_is_hit;
    logic [1:0]  r_lives;
    logic [9:0]  r_sx;
    logic [9:0]  r_sy;

    logic [2:0]  w_depth;
    logic        w_col_live;
    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic        w_ovl_x;
    logic        w_ovl_y;
    logic        w_retired;
    logic        w_hit;
    logic        w_retire;

    always_comb begin
        w_depth = 3'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_col_sel == c[2:0]) begin
                w_depth = col_depth[3*c +: 3];
            end
        end
    end

    assign w_col_live = col_alive[r_col_sel];
    assign w_sx = alien_base_x + 10'(r_col_sel) * COL_SPACING + {1'b0, ALIEN_W[9:1]};
    assign w_sy = alien_base_y + 10'(w_depth) * ROW_SPACING + ALIEN_H;

    // 11-bit sums keep the box edges from wrapping near the screen limits
    assign w_ovl_x = ({1'b0, projectile_x_pos} + {1'b0, PROJ_SIZE} >= {1'b0, player_x}) &&
                     ({1'b0, projectile_x_pos} <= {1'b0, player_x} + {1'b0, PLAYER_W} + {1'b0, PROJ_SIZE});
    assign w_ovl_y = ({1'b0, projectile_y_pos} + {1'b0, PROJ_SIZE} >= {1'b0, player_y}) &&
                     ({1'b0, projectile_y_pos} <= {1'b0, player_y} + {1'b0, PLAYER_H} + {1'b0, PROJ_SIZE});
    assign w_retired = (projectile_x_pos == 10'd0) && (projectile_y_pos == 10'd0);

    // A hit takes precedence over a retirement seen in the same cycle
    assign w_hit    = (r_state == S_FLIGHT) && w_ovl_x && w_ovl_y && !r_hit_done;
    assign w_retire = (r_state == S_FLIGHT) && w_retired && !w_hit;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_COOLDOWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COOLDOWN: if (r_frame_edge && (r_cd_cnt == 8'd0)) w_state_nxt = S_SELECT;
            S_SELECT:   if (w_col_live) w_state_nxt = S_ARMED;
            S_ARMED:    if (projectile_y_pos != 10'd0) w_state_nxt = S_FLIGHT;
            S_FLIGHT:   if (w_retire) w_state_nxt = (r_lives == 2'd0) ? S_HALT : S_COOLDOWN;
            S_HALT:     w_state_nxt = S_HALT;
            default:    w_state_nxt = S_COOLDOWN;
        endcase
    end

    always_comb begin
        shoot      = (r_state == S_ARMED);
        shooter_x  = r_sx;
        shooter_y  = r_sy;
        is_hit     = r_is_hit;
        player_hit = r_is_hit;
        lives      = r_lives;
        game_over  = (r_lives == 2'd0);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_frame_d    <= 1'b0;
            r_frame_edge <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_cd_cnt     <= COOLDOWN_MIN;
            r_col_sel    <= 3'd0;
            r_hit_done   <= 1'b0;
            r_is_hit     <= 1'b0;
            r_lives      <= INIT_LIVES;
            r_sx         <= 10'd0;
            r_sy         <= 10'd0;
        end else begin
            r_frame_d    <= frame_clk;
            r_frame_edge <= frame_clk & ~r_frame_d;
            r_lfsr       <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
            r_is_hit     <= 1'b0;
            case (r_state)
                S_COOLDOWN: begin
                    if (r_frame_edge) begin
                        if (r_cd_cnt == 8'd0) begin
                            r_col_sel <= r_lfsr[2:0];
                        end else begin
                            r_cd_cnt <= r_cd_cnt - 8'd1;
                        end
                    end
                end
                S_SELECT: begin
                    if (w_col_live) begin
                        r_sx <= w_sx;
                        r_sy <= w_sy;
                    end else begin
                        r_col_sel <= r_col_sel + 3'd1;
                    end
                end
                S_FLIGHT: begin
                    if (w_hit) begin
                        r_is_hit   <= 1'b1;
                        r_hit_done <= 1'b1;
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end else if (w_retire) begin
                        r_hit_done <= 1'b0;
                        r_cd_cnt   <= COOLDOWN_MIN + {2'b00, r_lfsr[5:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alien_fire_controller.sv
// ============================================================================
// Module   : tb_alien_fire_controller
// Brief    : Scoreboard bench for alien_fire_controller launch and hit logic.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alien_fire_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  alien_base_x = 10'd100;
    logic [9:0]  alien_base_y = 10'd50;
    logic [7:0]  col_alive = 8'h01;
    logic [23:0] col_depth = 24'd2;
    logic [9:0]  player_x = 10'd400;
    logic [9:0]  player_y = 10'd440;
    logic [9:0]  projectile_x_pos = 10'd0;
    logic [9:0]  projectile_y_pos = 10'd0;
    logic        shoot;
    logic [9:0]  shooter_x;
    logic [9:0]  shooter_y;
    logic        is_hit;
    logic        player_hit;
    logic [1:0]  lives;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_rises = 0;
    int shoot_frame = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    coord_t     sb_q[$];
    logic [1:0] lives_q[$];

    alien_fire_controller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .alien_base_x     (alien_base_x),
        .alien_base_y     (alien_base_y),
        .col_alive        (col_alive),
        .col_depth        (col_depth),
        .player_x         (player_x),
        .player_y         (player_y),
        .projectile_x_pos (projectile_x_pos),
        .projectile_y_pos (projectile_y_pos),
        .shoot            (shoot),
        .shooter_x        (shooter_x),
        .shooter_y        (shooter_y),
        .is_hit           (is_hit),
        .player_hit       (player_hit),
        .lives            (lives),
        .game_over        (game_over)
    );

    always #5 Clk = ~Clk;

    // Frame strobe: 4 Clk period, high for 2
    initial begin
        int ph;
        ph = 3;
        forever begin
            @(negedge Clk);
            ph = (ph + 1) % 4;
            frame_clk = (ph < 2);
            if (ph == 0) frame_rises++;
        end
    end

    function automatic coord_t exp_coord(input logic [9:0] bx, input logic [9:0] by,
                                         input int col, input int depth);
        coord_t e;
        e.x = bx + 10'(col * 40) + 10'd12;
        e.y = by + 10'(depth * 32) + 10'd16;
        return e;
    endfunction

    task automatic set_column(input logic [9:0] bx, input logic [9:0] by, input int col, input int depth);
        alien_base_x = bx;
        alien_base_y = by;
        col_alive = 8'h00;
        col_alive[col] = 1'b1;
        col_depth = 24'd0;
        col_depth[3*col +: 3] = 3'(depth);
        sb_q.push_back(exp_coord(bx, by, col, depth));
    endtask

    task automatic launch_scored(input string name);
        coord_t e;
        bit ok;
        e = sb_q.pop_front();
        ok = 1'b0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            @(negedge Clk);
            ok = shoot;
        end
        shoot_frame = frame_rises;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_shoot: shoot=0 after 1500 Clk, required 1", name);
        end
        n_tests++;
        if (shooter_x !== e.x || shooter_y !== e.y) begin
            n_fail++;
            $display("FAIL %s_coord: got (%0d,%0d), required (%0d,%0d)", name, shooter_x, shooter_y, e.x, e.y);
        end
    endtask

    task automatic accept_shot(input string name);
        projectile_x_pos = shooter_x;
        projectile_y_pos = shooter_y;
        @(negedge Clk);
        n_tests++;
        if (shoot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drop: shoot=%b after launch accepted, required 0", name, shoot);
        end
    endtask

    task automatic retire_shot();
        projectile_x_pos = 10'd0;
        projectile_y_pos = 10'd0;
        repeat (2) @(negedge Clk);
    endtask

    // Drives an overlapping position for 6 Clk and scores any is_hit pulses
    task automatic fly_hit(input string name, input logic [9:0] px, input logic [9:0] py,
                           output int pulses);
        int mism;
        logic [1:0] exp_l;
        pulses = 0;
        mism = 0;
        projectile_x_pos = px;
        projectile_y_pos = py;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (player_hit !== is_hit) mism++;
            if (is_hit === 1'b1) begin
                pulses++;
                n_tests++;
                if (lives_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_unexpected_hit: is_hit=1, required 0", name);
                end else begin
                    exp_l = lives_q.pop_front();
                    if (lives !== exp_l) begin
                        n_fail++;
                        $display("FAIL %s_lives: got %0d, required %0d", name, lives, exp_l);
                    end
                end
            end
        end
        n_tests++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s_player_hit: %0d cycles differ from is_hit, required 0", name, mism);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_tests++;
        if (lives !== 2'd3 || shoot !== 1'b0 || is_hit !== 1'b0 || player_hit !== 1'b0 ||
            game_over !== 1'b0 || shooter_x !== 10'd0 || shooter_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_values: lives=%0d shoot=%b hit=%b phit=%b go=%b sx=%0d sy=%0d, required 3 0 0 0 0 0 0",
                     lives, shoot, is_hit, player_hit, game_over, shooter_x, shooter_y);
        end
        Reset = 1'b1;
    endtask

    task automatic test_first_shot();
        int start;
        start = frame_rises;
        set_column(10'd100, 10'd50, 0, 2);
        launch_scored("first");
        n_tests++;
        if (shoot_frame - start < 29 || shoot_frame - start > 34) begin
            n_fail++;
            $display("FAIL first_cooldown: %0d frames to first shot, required 29..34", shoot_frame - start);
        end
        accept_shot("first");
        retire_shot();
    endtask

    task automatic test_column_select();
        set_column(10'd10, 10'd20, 7, 5);
        launch_scored("col7");
        accept_shot("col7");
        retire_shot();
        set_column(10'd1000, 10'd1000, 3, 7);
        launch_scored("col3_wrap");
        accept_shot("col3_wrap");
        retire_shot();
    endtask

    task automatic test_no_columns();
        int viol;
        viol = 0;
        col_alive = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            @(negedge Clk);
            if (shoot !== 1'b0) viol++;
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL no_columns: shoot high %0d cycles, required 0", viol);
        end
    endtask

    task automatic test_miss();
        int hits;
        int start;
        hits = 0;
        player_x = 10'd400;
        player_y = 10'd440;
        set_column(10'd100, 10'd50, 0, 2);
        launch_scored("miss");
        accept_shot("miss");
        for (int y = 150; y <= 470; y += 20) begin
            projectile_x_pos = 10'd112;
            projectile_y_pos = 10'(y);
            @(negedge Clk);
            if (is_hit !== 1'b0) hits++;
        end
        projectile_x_pos = 10'd0;
        projectile_y_pos = 10'd0;
        @(negedge Clk);
        if (is_hit !== 1'b0) hits++;
        start = frame_rises;
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL miss_no_hit: is_hit seen %0d cycles, required 0", hits);
        end
        sb_q.push_back(exp_coord(10'd100, 10'd50, 0, 2));
        launch_scored("miss_reload");
        n_tests++;
        if (shoot_frame - start < 30 || shoot_frame - start > 96) begin
            n_fail++;
            $display("FAIL miss_reload: %0d frames between shots, required 30..96", shoot_frame - start);
        end
    endtask

    task automatic test_hit();
        int pulses;
        player_x = 10'd100;
        player_y = 10'd440;
        accept_shot("hit");
        lives_q.push_back(2'd2);
        fly_hit("hit", 10'd112, 10'd444, pulses);
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL hit_pulses: %0d is_hit pulses, required 1", pulses);
        end
        retire_shot();
        n_tests++;
        if (lives !== 2'd2 || shoot !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_after: lives=%0d shoot=%b, required 2 0", lives, shoot);
        end
    endtask

    task automatic test_game_over();
        int pulses;
        int viol;
        set_column(10'd100, 10'd50, 0, 2);
        launch_scored("go1");
        accept_shot("go1");
        lives_q.push_back(2'd1);
        fly_hit("go1", 10'd120, 10'd450, pulses);
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL go1_pulses: %0d is_hit pulses, required 1", pulses);
        end
        retire_shot();
        set_column(10'd100, 10'd50, 0, 2);
        launch_scored("go2");
        accept_shot("go2");
        // Player at the origin: retirement and overlap coincide, hit wins
        player_x = 10'd0;
        player_y = 10'd0;
        lives_q.push_back(2'd0);
        fly_hit("go2", 10'd0, 10'd0, pulses);
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL go2_pulses: %0d is_hit pulses, required 1", pulses);
        end
        player_x = 10'd100;
        player_y = 10'd440;
        n_tests++;
        if (lives !== 2'd0 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL game_over: lives=%0d game_over=%b, required 0 1", lives, game_over);
        end
        viol = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge Clk);
            if (shoot !== 1'b0 || game_over !== 1'b1 || is_hit !== 1'b0) viol++;
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d bad cycles in 200 frames, required 0", viol);
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (lives !== 2'd3 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL go_reset: lives=%0d game_over=%b, required 3 0", lives, game_over);
        end
        Reset = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int hits;
        hits = 0;
        player_x = 10'd100;
        player_y = 10'd440;
        set_column(10'd100, 10'd50, 0, 2);
        launch_scored("midflight");
        accept_shot("midflight");
        projectile_x_pos = 10'd112;
        projectile_y_pos = 10'd444;
        Reset = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (is_hit !== 1'b0 || player_hit !== 1'b0 || shoot !== 1'b0 || shooter_x !== 10'd0 ||
            shooter_y !== 10'd0 || lives !== 2'd3 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: hit=%b phit=%b shoot=%b sx=%0d sy=%0d lives=%0d go=%b, required 0 0 0 0 0 3 0",
                     is_hit, player_hit, shoot, shooter_x, shooter_y, lives, game_over);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (is_hit !== 1'b0) hits++;
        end
        projectile_x_pos = 10'd0;
        projectile_y_pos = 10'd0;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (is_hit !== 1'b0) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL midflight_no_hit: is_hit seen %0d cycles, required 0", hits);
        end
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_column_select();
        test_no_columns();
        test_miss();
        test_hit();
        test_game_over();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
